// File: rtl/wbi_slave_endpoint.sv
// Daisy-chain to Wishbone slave endpoint: turns command beats into Wishbone
// bursts and returns read data / write completion through a one-deep response slot.
module wbi_slave_endpoint #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = 4,
  parameter int BL = 10
) (
  input  logic          mclk,
  input  logic          reset_n,
  output logic          wbd_cmd_wrdy_o,
  input  logic          wbd_cmd_wval_i,
  input  logic [AW-1:0] wbd_cmd_adr_i,
  input  logic          wbd_cmd_we_i,
  input  logic [DW-1:0] wbd_cmd_dat_i,
  input  logic [BW-1:0] wbd_cmd_sel_i,
  input  logic [3:0]    wbd_cmd_tid_i,
  input  logic [BL-1:0] wbd_cmd_bl_i,
  input  logic          wbd_res_rrdy_i,
  output logic          wbd_res_rval_o,
  output logic [DW-1:0] wbd_res_dat_o,
  output logic          wbd_res_ack_o,
  output logic          wbd_res_lack_o,
  output logic          wbd_res_err_o,
  output logic [3:0]    wbd_res_tid_o,
  output logic          wbs_cyc_o,
  output logic          wbs_stb_o,
  output logic          wbs_we_o,
  output logic [AW-1:0] wbs_adr_o,
  output logic [DW-1:0] wbs_dat_o,
  output logic [BW-1:0] wbs_sel_o,
  output logic [BL-1:0] wbs_bl_o,
  output logic          wbs_bry_o,
  input  logic [DW-1:0] wbs_dat_i,
  input  logic          wbs_ack_i,
  input  logic          wbs_lack_i,
  input  logic          wbs_err_i
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] WR    = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] WRSP  = 3'd4;
  localparam logic [BL-1:0] ONE_BL  = BL'(1);
  localparam logic [BL-1:0] ZERO_BL = BL'(0);

  logic [2:0]    state_r;
  logic [AW-1:0] adr_r;
  logic          we_r;
  logic [DW-1:0] dat_r;
  logic [BW-1:0] sel_r;
  logic [BL-1:0] bl_r;
  logic [BL-1:0] cnt_r;
  logic [3:0]    tid_r;
  logic          wvld_r;
  logic          err_flag_r;

  logic          rval_r;
  logic [DW-1:0] rdat_r;
  logic          rack_r;
  logic          rlack_r;
  logic          rerr_r;
  logic [3:0]    rtid_r;

  logic          slot_free_s;
  logic          last_s;
  logic          load_s;
  logic [DW-1:0] ld_dat_s;
  logic          ld_ack_s;
  logic          ld_lack_s;
  logic          ld_err_s;
  logic          unused_lack_s;

  // Slave-side last indication is advisory only; the beat counter ends bursts.
  assign unused_lack_s = wbs_lack_i;

  assign slot_free_s = ~rval_r | wbd_res_rrdy_i;
  assign last_s      = (cnt_r == ONE_BL);

  assign wbs_cyc_o      = (state_r == RD) | ((state_r == WR) & wvld_r);
  assign wbs_stb_o      = wbs_cyc_o;
  assign wbs_we_o       = we_r;
  assign wbs_adr_o      = adr_r;
  assign wbs_dat_o      = dat_r;
  assign wbs_sel_o      = sel_r;
  assign wbs_bl_o       = bl_r;
  assign wbd_res_rval_o = rval_r;
  assign wbd_res_dat_o  = rdat_r;
  assign wbd_res_ack_o  = rack_r;
  assign wbd_res_lack_o = rlack_r;
  assign wbd_res_err_o  = rerr_r;
  assign wbd_res_tid_o  = rtid_r;

  // Handshake outputs decoded from the current state.
  always_comb begin
    wbs_bry_o      = 1'b0;
    wbd_cmd_wrdy_o = 1'b0;
    case (state_r)
      IDLE:    wbd_cmd_wrdy_o = 1'b1;
      RD:      wbs_bry_o      = slot_free_s;
      WR: begin
        wbs_bry_o      = wvld_r;
        wbd_cmd_wrdy_o = ~wvld_r;
      end
      FLUSH:   wbd_cmd_wrdy_o = 1'b1;
      default: wbd_cmd_wrdy_o = 1'b0;
    endcase
  end

  // Response slot load request and contents.
  always_comb begin
    load_s    = 1'b0;
    ld_dat_s  = wbs_dat_i;
    ld_ack_s  = 1'b0;
    ld_lack_s = 1'b0;
    ld_err_s  = 1'b0;
    case (state_r)
      RD: begin
        if (slot_free_s && wbs_err_i) begin
          load_s    = 1'b1;
          ld_err_s  = 1'b1;
          ld_lack_s = 1'b1;
        end else if (slot_free_s && wbs_ack_i) begin
          load_s    = 1'b1;
          ld_ack_s  = 1'b1;
          ld_lack_s = last_s;
        end else begin
          load_s = 1'b0;
        end
      end
      WRSP: begin
        ld_dat_s  = {DW{1'b0}};
        ld_ack_s  = 1'b1;
        ld_lack_s = 1'b1;
        ld_err_s  = err_flag_r;
        if (slot_free_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      default: load_s = 1'b0;
    endcase
  end

  // Burst sequencing: command latch, beat counting, write data holding.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      adr_r      <= {AW{1'b0}};
      we_r       <= 1'b0;
      dat_r      <= {DW{1'b0}};
      sel_r      <= {BW{1'b0}};
      bl_r       <= {BL{1'b0}};
      cnt_r      <= {BL{1'b0}};
      tid_r      <= 4'd0;
      wvld_r     <= 1'b0;
      err_flag_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (wbd_cmd_wval_i) begin
            adr_r <= wbd_cmd_adr_i;
            we_r  <= wbd_cmd_we_i;
            sel_r <= wbd_cmd_sel_i;
            bl_r  <= wbd_cmd_bl_i;
            tid_r <= wbd_cmd_tid_i;
            cnt_r <= (wbd_cmd_bl_i == ZERO_BL) ? ONE_BL : wbd_cmd_bl_i;
            if (wbd_cmd_we_i) begin
              dat_r   <= wbd_cmd_dat_i;
              wvld_r  <= 1'b1;
              state_r <= WR;
            end else begin
              state_r <= RD;
            end
          end
        end
        RD: begin
          if (slot_free_s && wbs_err_i) begin
            state_r <= IDLE;
          end else if (slot_free_s && wbs_ack_i) begin
            cnt_r <= cnt_r - ONE_BL;
            if (last_s) state_r <= IDLE;
            else        state_r <= RD;
          end
        end
        WR: begin
          if (wvld_r && wbs_err_i) begin
            err_flag_r <= 1'b1;
            wvld_r     <= 1'b0;
            cnt_r      <= cnt_r - ONE_BL;
            state_r    <= last_s ? WRSP : FLUSH;
          end else if (wvld_r && wbs_ack_i) begin
            wvld_r <= 1'b0;
            cnt_r  <= cnt_r - ONE_BL;
            if (last_s) state_r <= WRSP;
            else        state_r <= WR;
          end else if (!wvld_r && wbd_cmd_wval_i) begin
            dat_r  <= wbd_cmd_dat_i;
            sel_r  <= wbd_cmd_sel_i;
            wvld_r <= 1'b1;
          end
        end
        FLUSH: begin
          // Remaining write beats after a slave error are drained without strobes.
          if (wbd_cmd_wval_i) begin
            if (last_s) state_r <= WRSP;
            else        cnt_r   <= cnt_r - ONE_BL;
          end
        end
        WRSP: begin
          if (slot_free_s) begin
            state_r    <= IDLE;
            err_flag_r <= 1'b0;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // One-deep response slot; load has priority over unload in the same cycle.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      rval_r  <= 1'b0;
      rdat_r  <= {DW{1'b0}};
      rack_r  <= 1'b0;
      rlack_r <= 1'b0;
      rerr_r  <= 1'b0;
      rtid_r  <= 4'd0;
    end else if (load_s) begin
      rval_r  <= 1'b1;
      rdat_r  <= ld_dat_s;
      rack_r  <= ld_ack_s;
      rlack_r <= ld_lack_s;
      rerr_r  <= ld_err_s;
      rtid_r  <= tid_r;
    end else if (wbd_res_rrdy_i) begin
      rval_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wbi_slave_endpoint.sv
// Directed bench for wbi_slave_endpoint: reads, writes, error flush, bl=0 and mid-burst reset.
module tb_wbi_slave_endpoint;

  logic        mclk = 1'b0;
  logic        reset_n;
  logic        wbd_cmd_wrdy_o;
  logic        wbd_cmd_wval_i;
  logic [31:0] wbd_cmd_adr_i;
  logic        wbd_cmd_we_i;
  logic [31:0] wbd_cmd_dat_i;
  logic [3:0]  wbd_cmd_sel_i;
  logic [3:0]  wbd_cmd_tid_i;
  logic [9:0]  wbd_cmd_bl_i;
  logic        wbd_res_rrdy_i;
  logic        wbd_res_rval_o;
  logic [31:0] wbd_res_dat_o;
  logic        wbd_res_ack_o;
  logic        wbd_res_lack_o;
  logic        wbd_res_err_o;
  logic [3:0]  wbd_res_tid_o;
  logic        wbs_cyc_o;
  logic        wbs_stb_o;
  logic        wbs_we_o;
  logic [31:0] wbs_adr_o;
  logic [31:0] wbs_dat_o;
  logic [3:0]  wbs_sel_o;
  logic [9:0]  wbs_bl_o;
  logic        wbs_bry_o;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_i;
  logic        wbs_lack_i;
  logic        wbs_err_i;

  int n_cmp = 0;
  int n_err = 0;
  int sent;
  int got;

  wbi_slave_endpoint dut (
    .mclk(mclk), .reset_n(reset_n),
    .wbd_cmd_wrdy_o(wbd_cmd_wrdy_o), .wbd_cmd_wval_i(wbd_cmd_wval_i),
    .wbd_cmd_adr_i(wbd_cmd_adr_i), .wbd_cmd_we_i(wbd_cmd_we_i),
    .wbd_cmd_dat_i(wbd_cmd_dat_i), .wbd_cmd_sel_i(wbd_cmd_sel_i),
    .wbd_cmd_tid_i(wbd_cmd_tid_i), .wbd_cmd_bl_i(wbd_cmd_bl_i),
    .wbd_res_rrdy_i(wbd_res_rrdy_i), .wbd_res_rval_o(wbd_res_rval_o),
    .wbd_res_dat_o(wbd_res_dat_o), .wbd_res_ack_o(wbd_res_ack_o),
    .wbd_res_lack_o(wbd_res_lack_o), .wbd_res_err_o(wbd_res_err_o),
    .wbd_res_tid_o(wbd_res_tid_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_bl_o(wbs_bl_o), .wbs_bry_o(wbs_bry_o), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_i(wbs_ack_i), .wbs_lack_i(wbs_lack_i), .wbs_err_i(wbs_err_i)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the falling edge.
  task automatic step();
    @(negedge mclk);
    #1;
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] tid, input logic [9:0] bl);
    wbd_cmd_wval_i = 1'b1;
    wbd_cmd_we_i   = we;
    wbd_cmd_adr_i  = adr;
    wbd_cmd_dat_i  = dat;
    wbd_cmd_sel_i  = 4'hF;
    wbd_cmd_tid_i  = tid;
    wbd_cmd_bl_i   = bl;
    step();
    wbd_cmd_wval_i = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    wbd_cmd_wval_i = 1'b0; wbd_cmd_adr_i = 32'h0; wbd_cmd_we_i = 1'b0;
    wbd_cmd_dat_i = 32'h0; wbd_cmd_sel_i = 4'h0; wbd_cmd_tid_i = 4'h0;
    wbd_cmd_bl_i = 10'd0; wbd_res_rrdy_i = 1'b1; wbs_dat_i = 32'h0;
    wbs_ack_i = 1'b0; wbs_lack_i = 1'b0; wbs_err_i = 1'b0;
    #22;
    chk("rst_rval", 64'(wbd_res_rval_o), 64'h0);
    chk("rst_cyc", 64'(wbs_cyc_o), 64'h0);
    chk("rst_stb", 64'(wbs_stb_o), 64'h0);
    chk("rst_adr", 64'(wbs_adr_o), 64'h0);
    step();
    reset_n = 1'b1;
    step();
    chk("rst_wrdy", 64'(wbd_cmd_wrdy_o), 64'h1);

    // Single-beat read.
    send_cmd(1'b0, 32'h100, 32'h0, 4'd3, 10'd1);
    chk("rd1_cyc", 64'(wbs_cyc_o), 64'h1);
    chk("rd1_stb", 64'(wbs_stb_o), 64'h1);
    chk("rd1_adr", 64'(wbs_adr_o), 64'h100);
    chk("rd1_we", 64'(wbs_we_o), 64'h0);
    chk("rd1_bl", 64'(wbs_bl_o), 64'h1);
    chk("rd1_bry", 64'(wbs_bry_o), 64'h1);
    wbs_ack_i = 1'b1; wbs_dat_i = 32'hA5A5_0001;
    step();
    wbs_ack_i = 1'b0;
    chk("rd1_rval", 64'(wbd_res_rval_o), 64'h1);
    chk("rd1_dat", 64'(wbd_res_dat_o), 64'hA5A5_0001);
    chk("rd1_ack", 64'(wbd_res_ack_o), 64'h1);
    chk("rd1_lack", 64'(wbd_res_lack_o), 64'h1);
    chk("rd1_err", 64'(wbd_res_err_o), 64'h0);
    chk("rd1_tid", 64'(wbd_res_tid_o), 64'h3);
    chk("rd1_cyc_end", 64'(wbs_cyc_o), 64'h0);
    step();
    chk("rd1_unload", 64'(wbd_res_rval_o), 64'h0);

    // Four-beat read with consumer stalled; slave keeps ack high even when not ready.
    send_cmd(1'b0, 32'h200, 32'h0, 4'd7, 10'd4);
    sent = 0; got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      wbd_res_rrdy_i = !(c >= 2 && c <= 5);
      #1;
      if (c >= 2 && c <= 5) chk("rd4_bry_full", 64'(wbs_bry_o), 64'h0);
      if (wbd_res_rval_o && wbd_res_rrdy_i) begin
        chk("rd4_dat", 64'(wbd_res_dat_o), 64'(32'hB0 + 32'(got)));
        chk("rd4_lack", 64'(wbd_res_lack_o), (got == 3) ? 64'h1 : 64'h0);
        chk("rd4_tid", 64'(wbd_res_tid_o), 64'h7);
        got++;
      end
      if (sent < 4) begin
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'hB0 + 32'(sent);
        if (wbs_bry_o) sent++;
      end else begin
        wbs_ack_i = 1'b0;
      end
      step();
    end
    wbs_ack_i = 1'b0;
    wbd_res_rrdy_i = 1'b1;
    chk("rd4_count", 64'(got), 64'd4);
    chk("rd4_cyc_end", 64'(wbs_cyc_o), 64'h0);

    // Three-beat write, one beat every two cycles.
    send_cmd(1'b1, 32'h300, 32'h11, 4'd5, 10'd3);
    chk("wr3_stb", 64'(wbs_stb_o), 64'h1);
    chk("wr3_we", 64'(wbs_we_o), 64'h1);
    chk("wr3_dat0", 64'(wbs_dat_o), 64'h11);
    chk("wr3_bry", 64'(wbs_bry_o), 64'h1);
    chk("wr3_wrdy_busy", 64'(wbd_cmd_wrdy_o), 64'h0);
    wbs_ack_i = 1'b1; step(); wbs_ack_i = 1'b0;
    chk("wr3_stb_gap", 64'(wbs_stb_o), 64'h0);
    chk("wr3_wrdy_free", 64'(wbd_cmd_wrdy_o), 64'h1);
    wbd_cmd_wval_i = 1'b1; wbd_cmd_dat_i = 32'h22; step(); wbd_cmd_wval_i = 1'b0;
    chk("wr3_dat1", 64'(wbs_dat_o), 64'h22);
    chk("wr3_adr_hold", 64'(wbs_adr_o), 64'h300);
    wbs_ack_i = 1'b1; step(); wbs_ack_i = 1'b0;
    wbd_cmd_wval_i = 1'b1; wbd_cmd_dat_i = 32'h33; step(); wbd_cmd_wval_i = 1'b0;
    chk("wr3_dat2", 64'(wbs_dat_o), 64'h33);
    wbs_ack_i = 1'b1; step(); wbs_ack_i = 1'b0;
    chk("wr3_stb_wrsp", 64'(wbs_stb_o), 64'h0);
    chk("wr3_no_rsp_yet", 64'(wbd_res_rval_o), 64'h0);
    step();
    chk("wr3_rval", 64'(wbd_res_rval_o), 64'h1);
    chk("wr3_dat", 64'(wbd_res_dat_o), 64'h0);
    chk("wr3_ack", 64'(wbd_res_ack_o), 64'h1);
    chk("wr3_lack", 64'(wbd_res_lack_o), 64'h1);
    chk("wr3_err", 64'(wbd_res_err_o), 64'h0);
    chk("wr3_tid", 64'(wbd_res_tid_o), 64'h5);
    step();

    // Four-beat write with slave error on beat 2; beats 3-4 drained.
    send_cmd(1'b1, 32'h400, 32'h41, 4'd9, 10'd4);
    wbs_ack_i = 1'b1; step(); wbs_ack_i = 1'b0;
    wbd_cmd_wval_i = 1'b1; wbd_cmd_dat_i = 32'h42; step(); wbd_cmd_wval_i = 1'b0;
    chk("wre_dat1", 64'(wbs_dat_o), 64'h42);
    wbs_err_i = 1'b1; step(); wbs_err_i = 1'b0;
    chk("wre_flush_stb", 64'(wbs_stb_o), 64'h0);
    chk("wre_flush_wrdy", 64'(wbd_cmd_wrdy_o), 64'h1);
    wbd_cmd_wval_i = 1'b1; wbd_cmd_dat_i = 32'h43; step();
    chk("wre_flush2_stb", 64'(wbs_stb_o), 64'h0);
    chk("wre_flush2_wrdy", 64'(wbd_cmd_wrdy_o), 64'h1);
    wbd_cmd_dat_i = 32'h44; step(); wbd_cmd_wval_i = 1'b0;
    chk("wre_wrsp_stb", 64'(wbs_stb_o), 64'h0);
    chk("wre_wrsp_wrdy", 64'(wbd_cmd_wrdy_o), 64'h0);
    step();
    chk("wre_rval", 64'(wbd_res_rval_o), 64'h1);
    chk("wre_err", 64'(wbd_res_err_o), 64'h1);
    chk("wre_lack", 64'(wbd_res_lack_o), 64'h1);
    chk("wre_ack", 64'(wbd_res_ack_o), 64'h1);
    chk("wre_tid", 64'(wbd_res_tid_o), 64'h9);
    step();
    chk("wre_single_rsp", 64'(wbd_res_rval_o), 64'h0);

    // bl=0 read behaves as one beat.
    send_cmd(1'b0, 32'h500, 32'h0, 4'd2, 10'd0);
    chk("bl0_stb", 64'(wbs_stb_o), 64'h1);
    chk("bl0_bl", 64'(wbs_bl_o), 64'h0);
    wbs_ack_i = 1'b1; wbs_dat_i = 32'hC0; step(); wbs_ack_i = 1'b0;
    chk("bl0_rval", 64'(wbd_res_rval_o), 64'h1);
    chk("bl0_lack", 64'(wbd_res_lack_o), 64'h1);
    chk("bl0_dat", 64'(wbd_res_dat_o), 64'hC0);
    chk("bl0_cyc_end", 64'(wbs_cyc_o), 64'h0);
    step();

    // Reset during an eight-beat read after beat 3.
    send_cmd(1'b0, 32'h600, 32'h0, 4'd4, 10'd8);
    for (int i = 0; i < 3; i++) begin
      wbs_ack_i = 1'b1; wbs_dat_i = 32'hD0 + 32'(i); step();
    end
    wbs_ack_i = 1'b0;
    chk("mid_rval_pre", 64'(wbd_res_rval_o), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rval", 64'(wbd_res_rval_o), 64'h0);
    chk("mid_rst_cyc", 64'(wbs_cyc_o), 64'h0);
    chk("mid_rst_stb", 64'(wbs_stb_o), 64'h0);
    chk("mid_rst_adr", 64'(wbs_adr_o), 64'h0);
    chk("mid_rst_bl", 64'(wbs_bl_o), 64'h0);
    chk("mid_rst_rdat", 64'(wbd_res_dat_o), 64'h0);
    step();
    reset_n = 1'b1;
    step(); step();
    chk("post_rst_rval", 64'(wbd_res_rval_o), 64'h0);
    chk("post_rst_cyc", 64'(wbs_cyc_o), 64'h0);
    chk("post_rst_wrdy", 64'(wbd_cmd_wrdy_o), 64'h1);
    send_cmd(1'b0, 32'h700, 32'h0, 4'd6, 10'd1);
    chk("post_adr", 64'(wbs_adr_o), 64'h700);
    chk("post_stb", 64'(wbs_stb_o), 64'h1);
    wbs_ack_i = 1'b1; wbs_dat_i = 32'hE6; step(); wbs_ack_i = 1'b0;
    chk("post_rval", 64'(wbd_res_rval_o), 64'h1);
    chk("post_dat", 64'(wbd_res_dat_o), 64'hE6);
    chk("post_tid", 64'(wbd_res_tid_o), 64'h6);
    chk("post_lack", 64'(wbd_res_lack_o), 64'h1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
